// File: rtl/change_dispenser_if.sv
// Refund/coin handshake bundle between a vending controller (master) and the change dispenser (slave).
interface change_dispenser_if;
    logic       refund_req;
    logic [5:0] refund_amt;
    logic       coin_ack;
    logic       stock_load;
    logic [7:0] stock_5;
    logic [7:0] stock_10;
    logic [7:0] stock_15;
    logic [3:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic       done;
    logic       short;
    logic [5:0] shortfall;

    modport master (
        output refund_req, refund_amt, coin_ack, stock_load, stock_5, stock_10, stock_15,
        input  coin_out, coin_valid, busy, done, short, shortfall
    );

    modport slave (
        input  refund_req, refund_amt, coin_ack, stock_load, stock_5, stock_10, stock_15,
        output coin_out, coin_valid, busy, done, short, shortfall
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays a refund in 15/10/5 coins through a present/ack handshake.
// Optional macro CHANGE_STOCK_EN adds per-denomination stock counters and the shortfall path.
module change_dispenser (
    input  logic                 clk,
    input  logic                 rst,
    change_dispenser_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, SELECT, PRESENT, GAP, DONE, SHORT} state_t;

    state_t     state_q, state_d;
    logic [5:0] rem_q, rem_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] coin_out_q, coin_out_d;
    logic       coin_valid_q, coin_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       short_q, short_d;
    logic [5:0] shortfall_q, shortfall_d;

    logic       ack_take;
    logic       avail_5, avail_10, avail_15;

    assign ack_take = (state_q == PRESENT) && coin_valid_q && bus.coin_ack;

`ifdef CHANGE_STOCK_EN
    logic [7:0] stk_5_q, stk_5_d;
    logic [7:0] stk_10_q, stk_10_d;
    logic [7:0] stk_15_q, stk_15_d;

    assign avail_5  = (stk_5_q  != 8'd0);
    assign avail_10 = (stk_10_q != 8'd0);
    assign avail_15 = (stk_15_q != 8'd0);

    always_comb begin
        stk_5_d  = stk_5_q;
        stk_10_d = stk_10_q;
        stk_15_d = stk_15_q;
        if (state_q == IDLE && bus.stock_load) begin
            stk_5_d  = bus.stock_5;
            stk_10_d = bus.stock_10;
            stk_15_d = bus.stock_15;
        end else if (ack_take) begin
            case (sel_q)
                2'd1:    if (stk_5_q  != 8'd0) stk_5_d  = stk_5_q  - 8'd1;
                2'd2:    if (stk_10_q != 8'd0) stk_10_d = stk_10_q - 8'd1;
                2'd3:    if (stk_15_q != 8'd0) stk_15_d = stk_15_q - 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stk_5_q  <= 8'd0;
            stk_10_q <= 8'd0;
            stk_15_q <= 8'd0;
        end else begin
            stk_5_q  <= stk_5_d;
            stk_10_q <= stk_10_d;
            stk_15_q <= stk_15_d;
        end
    end
`else
    logic unused_stock;

    assign unused_stock = ^{bus.stock_load, bus.stock_5, bus.stock_10, bus.stock_15};
    assign avail_5  = 1'b1;
    assign avail_10 = 1'b1;
    assign avail_15 = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (bus.refund_req) begin
                    if (bus.refund_amt != 6'd0) begin
                        rem_d   = bus.refund_amt;
                        state_d = SELECT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SELECT: begin
                if (rem_q >= 6'd3 && avail_15) begin
                    sel_d   = 2'd3;
                    state_d = PRESENT;
                end else if (rem_q >= 6'd2 && avail_10) begin
                    sel_d   = 2'd2;
                    state_d = PRESENT;
                end else if (rem_q >= 6'd1 && avail_5) begin
                    sel_d   = 2'd1;
                    state_d = PRESENT;
                end else begin
                    state_d = SHORT;
                end
            end
            PRESENT: begin
                if (ack_take) begin
                    rem_d   = rem_q - {4'd0, sel_q};
                    state_d = GAP;
                end
            end
            GAP:     state_d = (rem_q == 6'd0) ? DONE : SELECT;
            DONE:    state_d = IDLE;
            SHORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs trail the state by one edge; the coin drops on the very edge that takes the ack.
        coin_valid_d = (state_q == PRESENT) && !ack_take;
        coin_out_d   = coin_valid_d ? {sel_q, sel_q} : 4'b0000;
        busy_d       = (state_q != IDLE);
        done_d       = (state_q == DONE);
`ifdef CHANGE_STOCK_EN
        short_d      = (state_q == SHORT);
        shortfall_d  = (state_q == SHORT) ? rem_q : 6'd0;
`else
        short_d      = 1'b0;
        shortfall_d  = 6'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= 6'd0;
            sel_q        <= 2'd0;
            coin_out_q   <= 4'b0000;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            shortfall_q  <= 6'd0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            sel_q        <= sel_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            shortfall_q  <= shortfall_d;
        end
    end

    assign bus.coin_out   = coin_out_q;
    assign bus.coin_valid = coin_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.short      = short_q;
    assign bus.shortfall  = shortfall_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy coin-plan reference model.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    change_dispenser_if bus ();

    change_dispenser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef CHANGE_STOCK_EN
    localparam bit STOCK_ON = 1'b1;
`else
    localparam bit STOCK_ON = 1'b0;
`endif

    int passCount  = 0;
    int checkCount = 0;
    int modelStock [1:3];
    int expCoins [$];
    int obsCoins [$];
    int expShortfall;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: keep handing out the largest affordable coin still in stock; coin code value equals 5*units.
    function automatic void planRefund(input int amt);
        int remain;
        int pick;
        remain = amt;
        expCoins.delete();
        expShortfall = 0;
        while (remain > 0) begin
            pick = 0;
            for (int v = 3; v >= 1; v--)
                if (pick == 0 && v <= remain && (!STOCK_ON || modelStock[v] > 0)) pick = v;
            if (pick == 0) begin
                expShortfall = remain;
                break;
            end
            expCoins.push_back(5 * pick);
            remain -= pick;
            if (STOCK_ON) modelStock[pick]--;
        end
    endfunction

    task automatic loadStock(input int s5, input int s10, input int s15);
        bus.stock_5    = s5[7:0];
        bus.stock_10   = s10[7:0];
        bus.stock_15   = s15[7:0];
        bus.stock_load = 1'b1;
        step();
        bus.stock_load = 1'b0;
        modelStock[1] = s5;
        modelStock[2] = s10;
        modelStock[3] = s15;
    endtask

    // Drives junk refund/load requests only while the dispenser is definitely mid-refund.
    task automatic meddle(input bit enable);
        if (enable && bus.busy && !bus.done && !bus.short) begin
            bus.refund_req = 1'($urandom_range(0, 1));
            bus.refund_amt = 6'($urandom_range(0, 63));
            bus.stock_load = 1'($urandom_range(0, 1));
            bus.stock_5    = 8'($urandom_range(0, 255));
            bus.stock_10   = 8'($urandom_range(0, 255));
            bus.stock_15   = 8'($urandom_range(0, 255));
        end else begin
            bus.refund_req = 1'b0;
            bus.stock_load = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int amt, input int ackDelay, input bit doMeddle, input string tag);
        int  cyc, firstValid, lastAck, doneCyc, gotShortfall, code;
        bit  finished, sawDone, sawShort;
        planRefund(amt);
        obsCoins.delete();
        bus.refund_amt = amt[5:0];
        bus.refund_req = 1'b1;
        step();
        bus.refund_req = 1'b0;
        bus.refund_amt = 6'($urandom_range(0, 63));
        cyc = 0; firstValid = -1; lastAck = -1; doneCyc = -1; gotShortfall = 0;
        finished = 1'b0; sawDone = 1'b0; sawShort = 1'b0;
        while (!finished && cyc < 600) begin
            meddle(doMeddle);
            step();
            cyc++;
            if (bus.coin_valid) begin
                if (firstValid < 0) firstValid = cyc;
                if (lastAck >= 0) checkOutput({tag, "_coin_spacing"}, cyc - lastAck, 3);
                code = int'(bus.coin_out);
                obsCoins.push_back(code);
                for (int d = 0; d < ackDelay; d++) begin
                    meddle(doMeddle);
                    step();
                    cyc++;
                    checkOutput({tag, "_hold"}, int'(bus.coin_valid && bus.coin_out == code[3:0]), 1);
                end
                meddle(doMeddle);
                bus.coin_ack = 1'b1;
                step();
                cyc++;
                bus.coin_ack = 1'b0;
                lastAck = cyc;
                checkOutput({tag, "_gap"}, int'({bus.coin_valid, bus.coin_out}), 0);
            end
            if (bus.done) begin
                sawDone  = 1'b1;
                doneCyc  = cyc;
                finished = 1'b1;
            end
            if (bus.short) begin
                sawShort     = 1'b1;
                gotShortfall = int'(bus.shortfall);
                finished     = 1'b1;
            end
        end
        bus.refund_req = 1'b0;
        bus.stock_load = 1'b0;
        if (!finished) checkOutput({tag, "_timeout"}, 0, 1);
        checkOutput({tag, "_ncoins"}, obsCoins.size(), expCoins.size());
        for (int i = 0; i < obsCoins.size() && i < expCoins.size(); i++)
            checkOutput($sformatf("%s_coin%0d", tag, i), obsCoins[i], expCoins[i]);
        checkOutput({tag, "_done"}, int'(sawDone), int'(expShortfall == 0));
        checkOutput({tag, "_short"}, int'(sawShort), int'(expShortfall != 0));
        checkOutput({tag, "_shortfall"}, gotShortfall, expShortfall);
        if (expCoins.size() > 0) checkOutput({tag, "_latency"}, firstValid, 2);
        else checkOutput({tag, "_no_valid"}, firstValid, -1);
        if (amt == 0) checkOutput({tag, "_zero_done_cyc"}, doneCyc, 1);
        step();
        checkOutput({tag, "_pulse_end"}, int'({bus.done, bus.short, bus.shortfall}), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        bus.refund_req = 1'b0;
        bus.refund_amt = 6'd0;
        bus.coin_ack   = 1'b0;
        bus.stock_load = 1'b0;
        bus.stock_5    = 8'd0;
        bus.stock_10   = 8'd0;
        bus.stock_15   = 8'd0;
        modelStock[1] = 0;
        modelStock[2] = 0;
        modelStock[3] = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkOutput("rst_coin_out", int'(bus.coin_out), 0);
        checkOutput("rst_coin_valid", int'(bus.coin_valid), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_short", int'(bus.short), 0);
        checkOutput("rst_shortfall", int'(bus.shortfall), 0);

        loadStock(255, 255, 255);
        applyStimulus(6, 1, 1'b0, "r30");
        applyStimulus(4, 10, 1'b0, "r20_hold");
        loadStock(1, 1, 0);
        applyStimulus(5, 0, 1'b0, "limited");
        applyStimulus(0, 0, 1'b0, "zero");

        // Abandon a coin mid-presentation with reset, then pay a fresh refund.
        loadStock(255, 255, 255);
        bus.refund_amt = 6'd5;
        bus.refund_req = 1'b1;
        step();
        bus.refund_req = 1'b0;
        cyc = 0;
        while (!bus.coin_valid && cyc < 20) begin
            step();
            cyc++;
        end
        checkOutput("mid_reset_reached_present", int'(bus.coin_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        modelStock[1] = 0;
        modelStock[2] = 0;
        modelStock[3] = 0;
        checkOutput("mid_reset_outputs",
            int'({bus.coin_out, bus.coin_valid, bus.busy, bus.done, bus.short, bus.shortfall}), 0);
        applyStimulus(3, 0, 1'b0, "after_reset");

        loadStock(255, 255, 255);
        applyStimulus(7, 2, 1'b1, "meddle");

        for (int n = 0; n < 25; n++) begin
            if (STOCK_ON && ($urandom_range(0, 2) == 0))
                loadStock($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            applyStimulus($urandom_range(0, 63), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst are sampled only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 refund_req  input  1  single-cycle request to pay out refund_amt.
REQ-005 refund_amt  input  6  amount to pay out, in 5-unit steps (0..63).
REQ-006 coin_ack  input  1  hopper has taken the presented coin.
REQ-007 stock_load  input  1  load the coin stock counters.
REQ-008 stock_5, stock_10, stock_15  input  8 each  stock load values per denomination.
REQ-009 coin_out  output  4  coin code: 4'b0101 = 5, 4'b1010 = 10, 4'b1111 = 15, 4'b0000 = none.
REQ-010 coin_valid  output  1  coin_out holds a coin awaiting coin_ack.
REQ-011 busy  output  1  a refund is in progress (any state other than IDLE).
REQ-012 done  output  1  one-cycle pulse when the full amount has been paid.
REQ-013 short  output  1  one-cycle pulse when the stock cannot complete the refund.
REQ-014 shortfall  output  6  unpaid remainder; valid while short=1, 0 otherwise.

Function
REQ-015 The FSM SHALL have the states IDLE, SELECT, PRESENT, GAP, DONE and SHORT; all outputs SHALL be registered.
REQ-016 In IDLE, refund_req=1 with refund_amt>0 SHALL latch refund_amt into a 6-bit remainder rem and move to SELECT.
REQ-017 In IDLE, refund_req=1 with refund_amt=0 SHALL move to DONE with no coin presented.
REQ-018 refund_req SHALL be ignored in every state other than IDLE.
REQ-019 In SELECT, the block SHALL pick the greedy coin (largest value in 5-unit steps, 3/2/1, with value <= rem and that coin available) and move to PRESENT.
REQ-020 In SELECT, if no coin qualifies, the block SHALL move to SHORT.
REQ-021 In PRESENT, coin_out SHALL hold the selected code and coin_valid=1 until coin_ack is sampled high; there is no timeout.
REQ-022 On coin_ack in PRESENT, the block SHALL subtract the coin value from rem, decrement that coin's stock, and move to GAP.
REQ-023 coin_ack outside PRESENT SHALL be ignored.
REQ-024 GAP SHALL last exactly 1 cycle with coin_out=4'b0000 and coin_valid=0, then move to DONE if rem=0, else to SELECT.
REQ-025 DONE SHALL assert done for 1 cycle, then return to IDLE.
REQ-026 SHORT SHALL assert short=1 with shortfall=rem for 1 cycle, then return to IDLE.
REQ-027 Latency: refund_req sampled at edge N SHALL give coin_valid=1 after edge N+2; each further coin SHALL need 3 cycles plus the ack wait.
REQ-028 Stock counters SHALL saturate at 0 and never wrap; stock_load SHALL take effect only in IDLE and be ignored otherwise.
REQ-029 rem arithmetic SHALL never underflow, because a coin is selected only when its value <= rem.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set: state=IDLE, coin_out=4'b0000, coin_valid=0, busy=0, done=0, short=0, shortfall=0, rem=0, and all stock counters=0.
REQ-031 rst SHALL take priority over every input, including mid-PRESENT; the pending coin is abandoned and nothing is decremented.

Configuration
REQ-032 With CHANGE_STOCK_EN defined, stock counters SHALL be implemented and consulted in SELECT, and SHORT SHALL be reachable.
REQ-033 Without CHANGE_STOCK_EN, stock ports SHALL remain present but be ignored, every coin SHALL always be available, and short and shortfall SHALL be constantly 0.

Verification
REQ-034 rst=1 then release; refund_amt=6 (30), ack each coin 1 cycle after valid -> coins 1111, 1111 each followed by a 0000 gap, then a done pulse; no short.
REQ-035 refund_amt=4 (20), coin_ack held low for 10 cycles -> coin_out=1111 and coin_valid=1 stable throughout; after ack, 0101 is presented, then done.
REQ-036 CHANGE_STOCK_EN, stock 15/10/5 = 0/1/1, refund_amt=5 -> coins 1010, 0101, then short=1 with shortfall=2.
REQ-037 refund_amt=0 -> done pulse 1 cycle later, coin_valid never asserted.
REQ-038 rst asserted during PRESENT -> next cycle all outputs are 0, and a new refund_req=3 pays out a single 1111.
REQ-039 refund_req and stock_load pulsed while busy -> no effect on rem, the coin sequence, or the stock values.
